// File: rtl/img_pkg.sv
// Shared constants and FSM state type for the output-image streamer.
package img_pkg;

    localparam int unsigned IMG_DATA_W    = 8;
    localparam int unsigned IMG_ADDR_W    = 13;
    localparam int unsigned IMG_RAM_DEPTH = 2500;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StDrain = 3'd2,
        StTail  = 3'd3,
        StFin   = 3'd4
    } img_stream_state_t;

endpackage

// File: rtl/img_out_streamer_if.sv
// Control, RAM port B and transmit-stream signals of img_out_streamer.
// The slave modport is the streamer side; master is the surrounding system.
interface img_out_streamer_if #(
    parameter int unsigned DATA_W = img_pkg::IMG_DATA_W,
    parameter int unsigned ADDR_W = img_pkg::IMG_ADDR_W
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport slave (
        input  start, base_addr, length, ram_q, tx_ready,
        output busy, done, ram_addr, ram_we, ram_wdata, tx_data, tx_valid
    );

    modport master (
        output start, base_addr, length, ram_q, tx_ready,
        input  busy, done, ram_addr, ram_we, ram_wdata, tx_data, tx_valid
    );

endinterface

// File: rtl/img_skid_fifo2.sv
// Two-entry skid FIFO; the head entry always sits in r_head so the output
// is a plain register and stays stable while stalled.
module img_skid_fifo2
    import img_pkg::*;
#(
    parameter int unsigned DATA_W = IMG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_valid,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_rdata = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

    // Producer never pushes into a full FIFO unless it pops in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            unique case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= i_wdata;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push, w_pop})
                        2'b11: r_head <= i_wdata;
                        2'b10: begin
                            r_tail  <= i_wdata;
                            r_count <= 2'd2;
                        end
                        2'b01: r_count <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_wdata;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/img_out_streamer.sv
// Reads a downsampled image back from RAM port B and streams it as bytes.
// Define IMG_OUT_STREAMER_CSUM_EN to append an 8-bit sum byte to every transfer.
module img_out_streamer
    import img_pkg::*;
#(
    parameter int unsigned DATA_W    = IMG_DATA_W,
    parameter int unsigned ADDR_W    = IMG_ADDR_W,
    parameter int unsigned RAM_DEPTH = IMG_RAM_DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    img_out_streamer_if.slave io_bus
);

`ifdef IMG_OUT_STREAMER_CSUM_EN
    localparam img_stream_state_t EndState = StTail;
`else
    localparam img_stream_state_t EndState = StFin;
`endif

    img_stream_state_t r_state;
    img_stream_state_t w_state_next;

    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_tx_cnt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_in_flight;

    logic              w_accept;
    logic              w_issue;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic [ADDR_W-1:0] w_rd_ptr_inc;
    logic              w_fifo_valid;
    logic [DATA_W-1:0] w_fifo_data;
    logic [1:0]        w_fifo_count;

    img_skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_in_flight),
        .i_wdata (io_bus.ram_q),
        .i_pop   (io_bus.tx_ready),
        .o_rdata (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign w_accept = io_bus.start && ((r_state == StIdle) || (r_state == StFin));
    assign w_pop    = w_fifo_valid && io_bus.tx_ready;
    assign w_occ    = {1'b0, w_fifo_count} + {2'b00, r_in_flight};

    // Slots freed by this cycle's pop count, which keeps 1 byte/cycle sustained.
    assign w_issue = (r_state == StRead) &&
                     ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

    assign w_rd_ptr_inc = (r_rd_ptr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : r_rd_ptr + ADDR_W'(1);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StFin: begin
                w_state_next = StIdle;
                if (w_accept) begin
                    w_state_next = (io_bus.length == '0) ? EndState : StRead;
                end
            end
            StRead: begin
                if (w_issue && (r_rd_cnt == ADDR_W'(1))) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if ((r_tx_cnt == '0) || ((r_tx_cnt == ADDR_W'(1)) && w_pop)) begin
                    w_state_next = EndState;
                end
            end
            StTail: begin
                if (io_bus.tx_ready) begin
                    w_state_next = StFin;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_ram_addr  <= '0;
            r_in_flight <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_flight <= w_issue;
            if (w_accept) begin
                r_rd_ptr <= io_bus.base_addr;
                r_rd_cnt <= io_bus.length;
                r_tx_cnt <= io_bus.length;
            end else begin
                if (w_issue) begin
                    r_rd_ptr   <= w_rd_ptr_inc;
                    r_rd_cnt   <= r_rd_cnt - ADDR_W'(1);
                    r_ram_addr <= r_rd_ptr;
                end
                if (w_pop) begin
                    r_tx_cnt <= r_tx_cnt - ADDR_W'(1);
                end
            end
        end
    end

`ifdef IMG_OUT_STREAMER_CSUM_EN
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_pop) begin
            r_sum <= r_sum + w_fifo_data;
        end
    end

    assign io_bus.tx_valid = w_fifo_valid || (r_state == StTail);
    assign io_bus.tx_data  = (r_state == StTail) ? r_sum : w_fifo_data;
`else
    assign io_bus.tx_valid = w_fifo_valid;
    assign io_bus.tx_data  = w_fifo_data;
`endif

    // Address is live in the issue cycle so data arrives the cycle after.
    assign io_bus.ram_addr  = w_issue ? r_rd_ptr : r_ram_addr;
    assign io_bus.ram_we    = 1'b0;
    assign io_bus.ram_wdata = '0;
    assign io_bus.busy      = (r_state == StRead) || (r_state == StDrain) ||
                              (r_state == StTail);
    assign io_bus.done      = (r_state == StFin);

endmodule

// File: doc/img_out_streamer.md
Name: img_out_streamer

Overview:
- Reader/consumer end of the output-image RAM.
- After the processor finishes writing a downsampled image through RAM port A, this block reads the image back through port B, sequentially from a base address for a given byte count.
- Streams the bytes on a valid/ready byte interface toward the UART/DDR transmit path.
- Absorbs the 1-cycle RAM read latency and downstream backpressure with a 2-entry skid FIFO.

Parameters:
- DATA_W, 8, pixel width.
- ADDR_W, 13, RAM address width.
- RAM_DEPTH, 2500, RAM words; addresses wrap modulo RAM_DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; ignored while busy=1.
- base_addr  in  ADDR_W  first address; sampled on accepted start; must be < RAM_DEPTH.
- length  in  ADDR_W  byte count, 0..RAM_DEPTH; sampled on accepted start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the last byte (or checksum) is accepted downstream.
- ram_addr  out  ADDR_W  to RAM port B address.
- ram_we  out  1  to RAM port B write enable; constant 0.
- ram_wdata  out  DATA_W  to RAM port B write data; constant 0.
- ram_q  in  DATA_W  RAM port B registered read data, valid 1 cycle after address.
- tx_data  out  DATA_W  stream byte.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  downstream ready; transfer occurs when tx_valid && tx_ready.

Behaviour:
- Reset (async, rst_n=0) clears state to IDLE and FIFO contents. Resulting outputs: busy=0, done=0, tx_valid=0, tx_data=0, ram_addr=0, ram_we=0. Reset mid-transfer aborts immediately; no done pulse.
- FSM states: IDLE, READ, DRAIN, TAIL, FIN.
- IDLE:
  - On start: latch base_addr into rd_ptr, length into rd_cnt and into tx_cnt (bytes still to emit).
  - length=0 -> FIN. Otherwise -> READ.
- READ: issue a read (ram_addr=rd_ptr) in a cycle only when FIFO occupancy + reads in flight < 2. Each issue does all of:
  - rd_ptr increments; if it reaches RAM_DEPTH it wraps to 0.
  - rd_cnt decrements.
  - in_flight is set for the next cycle, when ram_q is pushed into the FIFO.
  - When rd_cnt reaches 0 -> DRAIN.
- DRAIN: wait until tx_cnt=0, then -> TAIL if IMG_OUT_STREAMER_CSUM_EN is defined, else -> FIN.
- TAIL: optional checksum byte (see below).
- FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
- FIFO:
  - 2 entries; tx_valid = FIFO non-empty; tx_data = head entry.
  - Push and pop in the same cycle are both legal, including when occupancy is 2.
  - Pop on tx_valid && tx_ready; tx_cnt decrements on each pop.
- Backpressure: tx_data and tx_valid hold stable while tx_valid && !tx_ready; no byte is lost or duplicated.
- Throughput: 1 byte/cycle sustained with tx_ready=1.
- Latency: start at cycle 0 -> ram_addr=base at cycle 1 -> first tx_valid at cycle 3.
- start while busy: ignored, with no effect on the latched parameters.
- ram_addr holds its last value when no read is issued.

Optional Feature:
- Macro IMG_OUT_STREAMER_CSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every byte popped from the FIFO; it is cleared on start.
  - In TAIL, tx_data=sum and tx_valid=1 until accepted, then -> FIN. Total bytes emitted = length+1, including when length=0 (checksum 0x00 is emitted).
- Undefined: no accumulator logic; TAIL is unreachable; exactly length bytes are emitted.

Decomposition:
- Shared package img_pkg: IMG_DATA_W=8, IMG_ADDR_W=13, IMG_RAM_DEPTH=2500, and the FSM state enum type img_stream_state_t.
- One natural sub-module: img_skid_fifo2 (2-entry FIFO with push/pop/count).

Test Plan:
- Fill RAM[0..9]=0x10..0x19, start base=0 len=10, tx_ready=1 -> bytes 0x10..0x19 on consecutive cycles 3..12; done at cycle 13; ram_we never 1.
- Same data, tx_ready toggling 1,0,0,1 pattern -> the same 10 bytes in order, tx_data stable while stalled, FIFO never exceeds 2.
- base=2498 len=4, RAM[2498]=0xA1, [2499]=0xA2, [0]=0xA3, [1]=0xA4 -> output A1,A2,A3,A4 (wrap at 2500).
- len=0 -> no tx_valid, done one cycle after start (CSUM_EN: single byte 0x00, then done).
- Start len=2500 with tx_ready=1, second start pulse at cycle 100, then rst_n=0 at cycle 500 -> second start ignored; outputs reset asynchronously, no done; a new start after reset restarts cleanly.
- CSUM_EN, bytes 0xFF,0x02,0x10 -> tail byte 0x11, then done.
